// File: rtl/alu_acc_if.sv
// Request/result bundle between the register file read port and the
// accumulator execute stage.
interface alu_acc_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             busy;
    logic             done;
    logic             wb_en;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             div0;

    modport master (
        output start, alu_op, op_a, op_b,
        input  acc, busy, done, wb_en, zero, carry, ovf, div0
    );

    modport slave (
        input  start, alu_op, op_a, op_b,
        output acc, busy, done, wb_en, zero, carry, ovf, div0
    );
endinterface

// File: rtl/alu_acc_unit.sv
// 8-bit execute stage: single-cycle logic/arith ops, 8-iteration shift-add
// multiply and restoring divide, result held in an accumulator with flags.
module alu_acc_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic     clk,
    input  logic     reset,
    alu_acc_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_WB
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } alu_res_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q, quo_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   acc_q;
    logic               zero_q, carry_q, ovf_q, div0_q;

    logic               accept, commit, last_iter;
    alu_res_t           ex_res;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] div_nxt;

    function automatic alu_res_t exec_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        alu_res_t                r;
        logic [WIDTH:0]          ext;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        r   = '0;
        ext = '0;
        sa  = a;
        sb  = b;
        case (op)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b};
                r.res   = ext[WIDTH-1:0];
                r.carry = ext[WIDTH];
                r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                ext     = {1'b0, a} - {1'b0, b};
                r.res   = ext[WIDTH-1:0];
                r.carry = ext[WIDTH];
                r.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            OP_SLT:  r.res = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] prod,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b,
        input logic [CNT_W-1:0]   cnt
    );
        logic [2*WIDTH-1:0] addend;
        addend = b[cnt] ? ({{WIDTH{1'b0}}, a} << cnt) : '0;
        return prod + addend;
    endfunction

    // Returns {remainder, quotient}; dividend bits shift out of quo MSB-first.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   shifted;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] rem_n;
        logic             qbit;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, b};
        if (shifted >= {1'b0, b}) begin
            rem_n = diff[WIDTH-1:0];
            qbit  = 1'b1;
        end else begin
            rem_n = shifted[WIDTH-1:0];
            qbit  = 1'b0;
        end
        return {rem_n, quo[WIDTH-2:0], qbit};
    endfunction

    assign ex_res  = exec_op(op_q, a_q, b_q);
    assign mul_nxt = mul_step(prod_q, a_q, b_q, cnt_q);
    assign div_nxt = div_step(rem_q, quo_q, b_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        last_iter = (cnt_q == {CNT_W{1'b1}});
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    case (bus.alu_op)
                        OP_MUL:  state_nxt = S_MUL;
                        OP_DIV:  state_nxt = S_DIV;
                        default: state_nxt = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                commit    = 1'b1;
                state_nxt = S_WB;
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    commit    = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_q    <= bus.op_a;
            b_q    <= bus.op_b;
            op_q   <= bus.alu_op;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= bus.op_a;
            cnt_q  <= '0;
        end else if (state == S_MUL) begin
            prod_q <= mul_nxt;
            cnt_q  <= cnt_q + 1'b1;
        end else if (state == S_DIV) begin
            {rem_q, quo_q} <= div_nxt;
            cnt_q          <= cnt_q + 1'b1;
        end
    end

    // Accumulator and flags change only when an operation completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else if (commit) begin
            case (state)
                S_MUL: begin
                    acc_q   <= mul_nxt[WIDTH-1:0];
                    zero_q  <= (mul_nxt[WIDTH-1:0] == '0);
                    carry_q <= |mul_nxt[2*WIDTH-1:WIDTH];
                    ovf_q   <= 1'b0;
                    div0_q  <= 1'b0;
                end
                S_DIV: begin
                    if (b_q == '0) begin
                        acc_q  <= {WIDTH{1'b1}};
                        zero_q <= 1'b0;
                        div0_q <= 1'b1;
                    end else begin
                        acc_q  <= div_nxt[WIDTH-1:0];
                        zero_q <= (div_nxt[WIDTH-1:0] == '0);
                        div0_q <= 1'b0;
                    end
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                end
                default: begin
                    acc_q   <= ex_res.res;
                    zero_q  <= (ex_res.res == '0);
                    carry_q <= ex_res.carry;
                    ovf_q   <= ex_res.ovf;
                    div0_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.acc   = acc_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;
    assign bus.ovf   = ovf_q;
    assign bus.div0  = div0_q;
    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = (state == S_WB);
    assign bus.wb_en = bus.done;
endmodule

// File: tb/tb_alu_acc_unit.sv
// Scoreboard bench for alu_acc_unit: expected results are queued at request
// time and compared when the done pulse appears.
module tb_alu_acc_unit;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef struct packed {
        logic [7:0] acc;
        logic       zero;
        logic       carry;
        logic       ovf;
        logic       div0;
    } res_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        res_t       r;
    } vec_t;

    typedef struct {
        res_t  r;
        int    lat;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_acc_if bus ();

    alu_acc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        int   sa, sb, s, p;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_ADD: begin
                s = int'(a) + int'(b);
                r.acc = s[7:0];
                r.carry = (s > 255);
                r.ovf = (sa + sb > 127) || (sa + sb < -128);
            end
            OP_SUB: begin
                s = int'(a) - int'(b);
                r.acc = s[7:0];
                r.carry = (a < b);
                r.ovf = (sa - sb > 127) || (sa - sb < -128);
            end
            OP_AND: r.acc = a & b;
            OP_OR:  r.acc = a | b;
            OP_XOR: r.acc = a ^ b;
            OP_SLT: r.acc = (sa < sb) ? 8'h01 : 8'h00;
            OP_MUL: begin
                p = int'(a) * int'(b);
                r.acc = p[7:0];
                r.carry = (p > 255);
            end
            default: begin
                if (b == 8'h00) begin
                    r.acc = 8'hFF;
                    r.div0 = 1'b1;
                end else begin
                    r.acc = a / b;
                end
            end
        endcase
        r.zero = (r.acc == 8'h00);
        return r;
    endfunction

    // Drives one request across its accepting edge; operands are scrambled after.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input res_t r, input string name, input bit track);
        exp_t e;
        @(negedge clk);
        bus.alu_op = op;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        if (track) begin
            e.r    = r;
            e.lat  = (op == OP_MUL || op == OP_DIV) ? 9 : 2;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op_a   = 8'($urandom);
        bus.op_b   = 8'($urandom);
        bus.alu_op = 3'($urandom);
    endtask

    // Latency counts the accepting edge as edge 1.
    task automatic wait_done(output res_t obs, output int lat, output bit timeout);
        lat     = 1;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        obs = {bus.acc, bus.zero, bus.carry, bus.ovf, bus.div0};
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.alu_op = 3'b000;
        bus.op_a   = 8'h00;
        bus.op_b   = 8'h00;
        #1;
        checks++;
        if ({bus.acc, bus.zero, bus.carry, bus.ovf, bus.div0, bus.busy, bus.done, bus.wb_en} !== 15'h0) begin
            failures++;
            $display("FAIL reset_state got acc=%h z=%b c=%b v=%b d0=%b busy=%b done=%b wb=%b required all 0",
                     bus.acc, bus.zero, bus.carry, bus.ovf, bus.div0, bus.busy, bus.done, bus.wb_en);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_table(input vec_t v[], input string tag);
        res_t o;
        int   lat;
        bit   to;
        exp_t e;
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].r, $sformatf("%s%0d", tag, i), 1'b1);
            wait_done(o, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || o !== e.r) begin
                failures++;
                $display("FAIL %s result {acc,z,c,v,d0} got=%h required=%h timeout=%0b", e.name, o, e.r, to);
            end
            checks++;
            if (lat != e.lat) begin
                failures++;
                $display("FAIL %s latency got=%0d required=%0d", e.name, lat, e.lat);
            end
            checks++;
            if (bus.wb_en !== 1'b1 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL %s wb_en_at_done got wb_en=%b busy=%b required 1,1", e.name, bus.wb_en, bus.busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.wb_en !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL %s pulse_width got done=%b wb_en=%b busy=%b required 0,0,0",
                         e.name, bus.done, bus.wb_en, bus.busy);
            end
        end
    endtask

    task automatic test_add();
        vec_t v[] = new[2];
        v[0] = '{OP_ADD, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0}};
        v[1] = '{OP_ADD, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
        run_table(v, "add");
    endtask

    task automatic test_sub_slt();
        vec_t v[] = new[4];
        v[0] = '{OP_SUB, 8'h05, 8'h05, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
        v[1] = '{OP_SUB, 8'h03, 8'h05, '{8'hFE, 1'b0, 1'b1, 1'b0, 1'b0}};
        v[2] = '{OP_SLT, 8'hFE, 8'h01, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0}};
        v[3] = '{OP_SUB, 8'h80, 8'h01, '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b0}};
        run_table(v, "sub_slt");
    endtask

    task automatic test_mul();
        vec_t v[] = new[2];
        v[0] = '{OP_MUL, 8'h0D, 8'h0B, '{8'h8F, 1'b0, 1'b0, 1'b0, 1'b0}};
        v[1] = '{OP_MUL, 8'h20, 8'h10, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
        run_table(v, "mul");
    endtask

    task automatic test_div();
        vec_t v[] = new[3];
        v[0] = '{OP_DIV, 8'hC8, 8'h07, '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0}};
        v[1] = '{OP_DIV, 8'h2A, 8'h00, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        v[2] = '{OP_XOR, 8'hAA, 8'hAA, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
        run_table(v, "div");
    endtask

    // Start pulses mid-MUL and during WB must both be dropped.
    task automatic test_busy_ignore();
        res_t o;
        int   pulses = 0;
        int   at = 0;
        int   edge_n = 1;
        exp_t e;
        issue(OP_MUL, 8'h13, 8'h07, '{8'h85, 1'b0, 1'b0, 1'b0, 1'b0}, "busy_ignore", 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
        @(negedge clk);
        bus.alu_op = OP_ADD;
        bus.op_a   = 8'h01;
        bus.op_b   = 8'h01;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        edge_n++;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_mul got=%b required=1", bus.busy);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                at = edge_n;
                o  = {bus.acc, bus.zero, bus.carry, bus.ovf, bus.div0};
                bus.alu_op = OP_ADD;
                bus.start  = 1'b1;
            end
        end
        e = sb.pop_front();
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL busy_ignore done_pulses got=%0d required=1", pulses);
        end
        checks++;
        if (o !== e.r) begin
            failures++;
            $display("FAIL busy_ignore result got=%h required=%h", o, e.r);
        end
        checks++;
        if (at != e.lat) begin
            failures++;
            $display("FAIL busy_ignore latency got=%0d required=%0d", at, e.lat);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.acc !== 8'h85) begin
            failures++;
            $display("FAIL busy_ignore hold got busy=%b acc=%h required 0,85", bus.busy, bus.acc);
        end
    endtask

    task automatic test_reset_abort();
        res_t o;
        int   lat;
        bit   to;
        int   pulses = 0;
        exp_t e;
        issue(OP_DIV, 8'h64, 8'h05, '0, "abort", 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.acc, bus.zero, bus.carry, bus.ovf, bus.div0, bus.busy, bus.done, bus.wb_en} !== 15'h0) begin
            failures++;
            $display("FAIL abort_reset got acc=%h z=%b c=%b v=%b d0=%b busy=%b done=%b required all 0",
                     bus.acc, bus.zero, bus.carry, bus.ovf, bus.div0, bus.busy, bus.done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.wb_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got pulses=%0d busy=%b required 0,0", pulses, bus.busy);
        end
        issue(OP_AND, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}, "abort_and", 1'b1);
        wait_done(o, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || o !== e.r || lat != e.lat) begin
            failures++;
            $display("FAIL %s result got=%h lat=%0d required=%h lat=%0d", e.name, o, lat, e.r, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        res_t o;
        int   lat;
        bit   to;
        exp_t e;
        logic [2:0] op;
        logic [7:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'(i % 8);
            a  = 8'($urandom);
            b  = (i == 15) ? 8'h00 : 8'($urandom);
            issue(op, a, b, model(op, a, b), $sformatf("b2b%0d_op%0d_%h_%h", i, op, a, b), 1'b1);
            wait_done(o, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || o !== e.r || lat != e.lat) begin
                failures++;
                $display("FAIL %s got=%h lat=%0d required=%h lat=%0d", e.name, o, lat, e.r, e.lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_mul();
        test_div();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_acc_unit.md
Name: alu_acc_unit

Overview:
- 8-bit execute stage directly downstream of the register file.
- Consumes the two register read operands, executes one ALU operation per request, and holds the result in the accumulator.
- Raises a one-cycle write-back strobe that drives the register file write enable, so the accumulator value can be stored to the destination register.
- Single-cycle logic ops; multi-cycle shift-add multiply and restoring divide.

Parameters:
- WIDTH, 8, datapath width; only 8 is supported.
- CNT_W, 3, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- alu_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 MUL, 111 DIV.
- op_a  input  8  operand A (register file data 1).
- op_b  input  8  operand B (register file data 2).
- acc  output  8  accumulator; result of the last completed operation.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse while in WB.
- wb_en  output  1  equal to done; drives the register file write enable.
- zero  output  1  acc == 0 for the last result.
- carry  output  1  ADD: carry-out. SUB: borrow (op_a < op_b unsigned). MUL: high product byte nonzero. Otherwise 0.
- ovf  output  1  signed overflow for ADD/SUB; 0 otherwise.
- div0  output  1  last DIV had op_b == 0.

Behaviour:
- Reset is asynchronous, active-high. It forces state IDLE, acc = 0, all flags = 0, busy = 0, done = 0, wb_en = 0, internal operand/product/remainder registers = 0, counter = 0.
- Reset mid-operation aborts the operation; no done or wb_en pulse follows.
- States: IDLE, EXEC, MUL, DIV, WB.
- IDLE:
  - On start = 1 at edge N, latch op_a, op_b and alu_op.
  - Go to MUL if alu_op = 110, DIV if 111, else EXEC. Counter cleared.
- EXEC:
  - At edge N+1, compute the result combinationally from the latched operands.
  - Register acc and the flags; go to WB.
  - ADD/SUB are modulo 256. SLT is a signed compare: acc = 8'h01 if a < b, else 8'h00.
- MUL:
  - One shift-add iteration per edge, on edges N+1 through N+8; counter 0..7.
  - The 16-bit product is kept internally.
  - At edge N+8: acc = product[7:0], carry = |product[15:8]; go to WB.
- DIV:
  - Unsigned restoring divide, one iteration per edge, on edges N+1 through N+8.
  - At edge N+8: acc = quotient; remainder kept internally and not exported; go to WB.
  - If op_b == 0: run the same 8 cycles, then acc = 8'hFF and div0 = 1.
- WB:
  - done = wb_en = 1 for exactly one cycle; next edge returns to IDLE.
  - done is high between edge N+1 and N+2 for single-cycle ops, and between edge N+8 and N+9 for MUL/DIV.
- Timing and flags:
  - zero is updated together with acc.
  - ovf and div0 are cleared by any non-applicable operation.
  - acc and the flags hold their value from WB until the next operation completes.
- start while busy (including during WB) is ignored and not queued. A new request is accepted in the cycle after WB, back in IDLE.
- Operand inputs may change freely after the accepting edge; only the latched copies are used.
- Back-to-back throughput: one single-cycle op every 3 cycles.

Test Plan:
- Reset, then ADD a=8'h7F, b=8'h01 -> at done: acc=8'h80, ovf=1, carry=0, zero=0, wb_en pulses for exactly 1 cycle, 2 edges after start.
- SUB a=8'h05, b=8'h05 -> acc=0, zero=1, carry=0. Then SUB a=8'h03, b=8'h05 -> acc=8'hFE, carry=1. Then SLT a=8'hFE, b=8'h01 -> acc=8'h01.
- MUL a=8'h0D, b=8'h0B -> done exactly 9 edges after start, acc=8'h8F, carry=0. Then MUL a=8'h20, b=8'h10 -> acc=8'h00, carry=1, zero=1.
- DIV a=8'hC8, b=8'h07 -> acc=8'h1C, div0=0. Then DIV a=8'h2A, b=0 -> acc=8'hFF, div0=1, same 9-edge latency.
- Pulse start with alu_op=ADD during a MUL in progress -> ignored; the MUL result is unchanged and only one done pulse occurs.
- Assert reset at iteration 4 of a DIV -> acc=0, all flags 0, busy=0, no done. A fresh AND a=8'hF0, b=8'h3C afterwards -> acc=8'h30.
